// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: walks two WIDTH-bit operands MSB-first, one 2-bit
// digit per clock, and reports gt/eq/lt on c0/c1/c2 with a one-cycle done pulse.
module serial_mag_compare_ctrl #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  start,
  input  logic [WIDTH-1:0]                                      a,
  input  logic [WIDTH-1:0]                                      b,
  output logic                                                  busy,
  output logic                                                  done,
  output logic                                                  c0,
  output logic                                                  c1,
  output logic                                                  c2,
  output logic [(((WIDTH/2) > 1) ? $clog2(WIDTH/2) : 1)-1:0]    digit
);

  localparam int DIGITS = WIDTH / 2;
  localparam int DW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("serial_mag_compare_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic             found, found_gt;
  logic [1:0]       cur_a, cur_b;
  logic             diff, last, go_done, res_found, res_gt;

  assign cur_a = sh_a[2*digit +: 2];
  assign cur_b = sh_b[2*digit +: 2];
  assign busy  = (state == COMPARE);
  assign done  = (state == DONE);

  // The first differing digit decides the result; later digits are only
  // scanned (and ignored) when EARLY_EXIT is off.
  always_comb begin
    diff       = (cur_a != cur_b);
    last       = (digit == '0);
    res_found  = found | diff;
    res_gt     = found ? found_gt : (cur_a > cur_b);
    go_done    = last || (EARLY_EXIT && diff);
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COMPARE;
      COMPARE: if (go_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a     <= '0;
      sh_b     <= '0;
      digit    <= '0;
      found    <= 1'b0;
      found_gt <= 1'b0;
      c0       <= 1'b0;
      c1       <= 1'b0;
      c2       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a     <= a;
            sh_b     <= b;
            digit    <= DW'(DIGITS - 1);
            found    <= 1'b0;
            found_gt <= 1'b0;
            c0       <= 1'b0;
            c1       <= 1'b0;
            c2       <= 1'b0;
          end
        end
        COMPARE: begin
          if (diff && !found) begin
            found    <= 1'b1;
            found_gt <= (cur_a > cur_b);
          end
          if (go_done) begin
            c0 <= res_found & res_gt;
            c1 <= ~res_found;
            c2 <= res_found & ~res_gt;
          end else begin
            digit <= digit - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Bench for serial_mag_compare_ctrl: three instances (8-bit early exit, 8-bit fixed
// latency, 2-bit) checked every cycle against a cycle-count model of the compare.
module tb_serial_mag_compare_ctrl;

  logic       clk, rst_n, start;
  logic [7:0] a, b;

  logic       busy0, done0, c00, c10, c20;
  logic [1:0] dig0;
  logic       busy1, done1, c01, c11, c21;
  logic [1:0] dig1;
  logic       busy2, done2, c02, c12, c22;
  logic       dig2;

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .c0(c00), .c1(c10), .c2(c20), .digit(dig0));

  serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut_fixed (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy1), .done(done1), .c0(c01), .c1(c11), .c2(c21), .digit(dig1));

  serial_mag_compare_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[1:0]), .b(b[1:0]),
    .busy(busy2), .done(done2), .c0(c02), .c1(c12), .c2(c22), .digit(dig2));

  logic [2:0] busy_v, done_v;
  logic [2:0] flag_v [3];
  int         dig_v  [3];

  assign busy_v    = {busy2, busy1, busy0};
  assign done_v    = {done2, done1, done0};
  assign flag_v[0] = {c00, c10, c20};
  assign flag_v[1] = {c01, c11, c21};
  assign flag_v[2] = {c02, c12, c22};
  assign dig_v[0]  = int'(dig0);
  assign dig_v[1]  = int'(dig1);
  assign dig_v[2]  = int'(dig2);

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: digits examined and gt/eq/lt computed arithmetically on capture
  localparam int  M_DIGITS [3] = '{4, 4, 1};
  localparam bit  M_EE     [3] = '{1'b1, 1'b0, 1'b1};

  int         m_left [3];
  int         m_dig  [3];
  bit         m_done [3];
  logic [2:0] m_res  [3];
  logic [2:0] m_pend [3];
  logic [7:0] mx, my;

  function automatic int digitsExamined(input int d, input bit ee, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] dif;
    int top;
    dif = x ^ y;
    top = -1;
    if (!ee || dif == 8'h00) return d;
    for (int k = 0; k < 8; k++) if (dif[k]) top = k;
    return d - top / 2;
  endfunction

  function automatic logic [2:0] expectFlags(input logic [7:0] x, input logic [7:0] y);
    if (x > y)  return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_left[i] = 0; m_dig[i] = 0; m_done[i] = 1'b0;
        m_res[i] = 3'b000; m_pend[i] = 3'b000;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_done[i]) begin
          m_done[i] = 1'b0;
        end else if (m_left[i] > 0) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_done[i] = 1'b1;
            m_res[i]  = m_pend[i];
          end else begin
            m_dig[i]--;
          end
        end else if (start) begin
          mx = (i == 2) ? (a & 8'h03) : a;
          my = (i == 2) ? (b & 8'h03) : b;
          m_left[i] = digitsExamined(M_DIGITS[i], M_EE[i], mx, my);
          m_dig[i]  = M_DIGITS[i] - 1;
          m_res[i]  = 3'b000;
          m_pend[i] = expectFlags(mx, my);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(m_left[i] > 0));
        checkOutput($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(m_done[i]));
        checkOutput($sformatf("flags[%0d]", i), 32'(flag_v[i]), 32'(m_res[i]));
        if (m_left[i] > 0)
          checkOutput($sformatf("digit[%0d]", i), 32'(dig_v[i]), 32'(m_dig[i]));
      end
    end
  end

  int lat [3];
  int dig_trace [8];
  int ntrace;

  task automatic applyStimulus(input logic [7:0] va, input logic [7:0] vb);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runCompare(input logic [7:0] va, input logic [7:0] vb);
    applyStimulus(va, vb);
    lat = '{0, 0, 0};
    ntrace = 0;
    if (busy0) begin dig_trace[ntrace] = int'(dig0); ntrace++; end
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (done_v[i] && lat[i] == 0) lat[i] = k;
      if (busy0 && ntrace < 8) begin dig_trace[ntrace] = int'(dig0); ntrace++; end
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    checkOutput("reset_busy", 32'(busy0), 32'd0);
    checkOutput("reset_done", 32'(done0), 32'd0);
    checkOutput("reset_flags", 32'(flag_v[0]), 32'd0);
    checkOutput("reset_digit", 32'(dig0), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    runCompare(8'hA5, 8'hA5);
    checkOutput("eq_lat_ee", 32'(lat[0]), 32'd4);
    checkOutput("eq_lat_fixed", 32'(lat[1]), 32'd4);
    checkOutput("eq_flags", 32'(flag_v[0]), 32'b010);

    runCompare(8'hC0, 8'h40);
    checkOutput("gt_lat_ee", 32'(lat[0]), 32'd1);
    checkOutput("gt_lat_fixed", 32'(lat[1]), 32'd4);
    checkOutput("gt_flags_ee", 32'(flag_v[0]), 32'b100);
    checkOutput("gt_flags_fixed", 32'(flag_v[1]), 32'b100);

    runCompare(8'h12, 8'h13);
    checkOutput("lt_lat", 32'(lat[0]), 32'd4);
    checkOutput("lt_flags", 32'(flag_v[0]), 32'b001);
    checkOutput("lt_trace_len", 32'(ntrace), 32'd4);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("lt_trace%0d", k), 32'(dig_trace[k]), 32'(3 - k));

    runCompare(8'hC1, 8'h43);
    checkOutput("first_diff_fixed", 32'(flag_v[1]), 32'b100);
    checkOutput("first_diff_lat", 32'(lat[1]), 32'd4);

    // Abort a long compare with an asynchronous reset between clock edges
    applyStimulus(8'h12, 8'h13);
    @(posedge clk); #1;
    checkOutput("pre_abort_busy", 32'(busy0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'({busy1, busy0}), 32'd0);
    checkOutput("abort_done", 32'({done1, done0}), 32'd0);
    checkOutput("abort_flags", 32'({flag_v[1], flag_v[0]}), 32'd0);
    checkOutput("abort_digit", 32'(dig0), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end

    // Back-to-back compares with operands changing every cycle
    start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; end

    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        runCompare({6'($urandom), 2'(x)}, {6'($urandom), 2'(y)});
        checkOutput($sformatf("w2_lat_%0d_%0d", x, y), 32'(lat[2]), 32'd1);
        checkOutput($sformatf("w2_flags_%0d_%0d", x, y), 32'(flag_v[2]),
                    (x > y) ? 32'b100 : ((x == y) ? 32'b010 : 32'b001));
      end
    end

    for (int k = 0; k < 10; k++) runCompare(8'($urandom), 8'($urandom));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
